// File: rtl/uart_score_tx.sv
// rtl/uart_score_tx.sv - Pong scoreboard: BCD point counters and "P1 dd P2 dd\r\n" UART line per change
module uart_score_tx #(
   parameter int CLKS_PER_BIT = 217
) (
   input  logic       i_CLK,
   input  logic       i_RST,
   input  logic       i_p1_scored,
   input  logic       i_p2_scored,
   input  logic       i_clear,
   output logic       o_Tx_Serial,
   output logic       o_Tx_Active,
   output logic       o_Tx_Done,
   output logic [7:0] o_p1_score,
   output logic [7:0] o_p2_score
);
   localparam logic [11:0] BIT_LAST = 12'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT_BYTE, S_DONE} seq_t;
   typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} ser_t;

   logic [2:0]  raw;
   logic [2:0]  sync1;
   logic [2:0]  sync2;
   logic [2:0]  prev;
   logic [2:0]  event_r;
   logic        pending;
   seq_t        seq_state;
   ser_t        ser_state;
   logic [3:0]  idx;
   logic [15:0] snap;
   logic [11:0] bit_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   logic        byte_done;
   logic        ser_load;
   logic [7:0]  ser_data;

   assign raw = {i_clear, i_p2_scored, i_p1_scored};

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'd9) begin
         r[3:0] = 4'd0;
         r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   function automatic logic [7:0] msg_byte(input logic [3:0] i, input logic [15:0] s);
      logic [7:0] b;
      case (i)
         4'd0, 4'd6: b = 8'h50;
         4'd1:       b = 8'h31;
         4'd7:       b = 8'h32;
         4'd3:       b = {4'h3, s[15:12]};
         4'd4:       b = {4'h3, s[11:8]};
         4'd9:       b = {4'h3, s[7:4]};
         4'd10:      b = {4'h3, s[3:0]};
         4'd11:      b = 8'h0D;
         4'd12:      b = 8'h0A;
         default:    b = 8'h20;
      endcase
      return b;
   endfunction

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         sync1      <= 3'b000;
         sync2      <= 3'b000;
         prev       <= 3'b000;
         event_r    <= 3'b000;
         pending    <= 1'b0;
         o_p1_score <= 8'h00;
         o_p2_score <= 8'h00;
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         prev    <= sync2;
         event_r <= sync2 & ~prev;
         if (event_r[2]) begin
            o_p1_score <= 8'h00;
            o_p2_score <= 8'h00;
         end else begin
            if (event_r[0]) o_p1_score <= bcd_inc(o_p1_score);
            if (event_r[1]) o_p2_score <= bcd_inc(o_p2_score);
         end
         // a new event wins over the LOAD clear so a follow-up line is never lost
         if (|event_r)
            pending <= 1'b1;
         else if (seq_state == S_LOAD)
            pending <= 1'b0;
      end
   end

   assign byte_done = (ser_state == T_STOP) && (bit_cnt == BIT_LAST);
   assign ser_load  = (seq_state == S_LOAD) ||
                      ((seq_state == S_WAIT_BYTE) && byte_done && (idx != 4'd12));
   // byte 0 is always 'P', so it can go out before the snapshot register settles
   assign ser_data  = (seq_state == S_LOAD) ? 8'h50 : msg_byte(idx + 4'd1, snap);

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         seq_state   <= S_IDLE;
         idx         <= 4'd0;
         snap        <= 16'h0000;
         o_Tx_Active <= 1'b0;
         o_Tx_Done   <= 1'b0;
      end else begin
         o_Tx_Done <= 1'b0;
         case (seq_state)
            S_IDLE: if (pending) seq_state <= S_LOAD;
            S_LOAD: begin
               snap        <= {o_p1_score, o_p2_score};
               idx         <= 4'd0;
               o_Tx_Active <= 1'b1;
               seq_state   <= S_SEND;
            end
            S_SEND: seq_state <= S_WAIT_BYTE;
            S_WAIT_BYTE: begin
               if (byte_done) begin
                  if (idx == 4'd12) begin
                     o_Tx_Done   <= 1'b1;
                     o_Tx_Active <= 1'b0;
                     seq_state   <= S_DONE;
                  end else begin
                     idx       <= idx + 4'd1;
                     seq_state <= S_SEND;
                  end
               end
            end
            S_DONE:  seq_state <= S_IDLE;
            default: seq_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         ser_state   <= T_IDLE;
         bit_cnt     <= 12'd0;
         bit_idx     <= 3'd0;
         shreg       <= 8'h00;
         o_Tx_Serial <= 1'b1;
      end else begin
         case (ser_state)
            T_IDLE: begin
               if (ser_load) begin
                  shreg       <= ser_data;
                  bit_cnt     <= 12'd0;
                  o_Tx_Serial <= 1'b0;
                  ser_state   <= T_START;
               end
            end
            T_START: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt     <= 12'd0;
                  bit_idx     <= 3'd0;
                  o_Tx_Serial <= shreg[0];
                  ser_state   <= T_DATA;
               end else begin
                  bit_cnt <= bit_cnt + 12'd1;
               end
            end
            T_DATA: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= 12'd0;
                  if (bit_idx == 3'd7) begin
                     o_Tx_Serial <= 1'b1;
                     ser_state   <= T_STOP;
                  end else begin
                     bit_idx     <= bit_idx + 3'd1;
                     shreg       <= {1'b0, shreg[7:1]};
                     o_Tx_Serial <= shreg[1];
                  end
               end else begin
                  bit_cnt <= bit_cnt + 12'd1;
               end
            end
            T_STOP: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= 12'd0;
                  // chain straight into the next start bit so a line has no idle gaps
                  if (ser_load) begin
                     shreg       <= ser_data;
                     o_Tx_Serial <= 1'b0;
                     ser_state   <= T_START;
                  end else begin
                     ser_state <= T_IDLE;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 12'd1;
               end
            end
            default: ser_state <= T_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_score_tx.sv
// tb/tb_uart_score_tx.sv - scoreboard bench for uart_score_tx: serial decode against expected score lines
module tb_uart_score_tx;
   localparam int CPB  = 4;
   localparam int HALF = CPB / 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       p1 = 1'b0;
   logic       p2 = 1'b0;
   logic       clr = 1'b0;
   logic       tx;
   logic       active;
   logic       done;
   logic [7:0] s1;
   logic [7:0] s2;

   uart_score_tx #(.CLKS_PER_BIT(CPB)) dut (
      .i_CLK(clk),
      .i_RST(rst),
      .i_p1_scored(p1),
      .i_p2_scored(p2),
      .i_clear(clr),
      .o_Tx_Serial(tx),
      .o_Tx_Active(active),
      .o_Tx_Done(done),
      .o_p1_score(s1),
      .o_p2_score(s2)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_pass = 0;
   logic [7:0] exp_q[$];
   int         rx_count = 0;
   int         done_count = 0;
   int         line_bytes = 0;
   int         m1 = 0;
   int         m2 = 0;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   function automatic int bcd(input int v);
      return (v / 10) * 16 + (v % 10);
   endfunction

   task automatic push_line(input int a, input int b);
      string s;
      s = $sformatf("P1 %02d P2 %02d\r\n", a, b);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
   endtask

   // serial monitor: decodes 8N1 frames, pops the scoreboard on every byte
   int         rx_t = 0;
   bit         rx_busy = 1'b0;
   logic [7:0] rx_sh = 8'h00;
   logic       prev_done = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         rx_busy    = 1'b0;
         line_bytes = 0;
         prev_done  = 1'b0;
      end else begin
         if (done) begin
            done_count++;
            check("done_width", int'(prev_done), 0);
            check("active_at_done", int'(active), 0);
            check("line_len", line_bytes, 13);
            line_bytes = 0;
         end
         prev_done = done;
         if (!rx_busy) begin
            if (!tx) begin
               rx_busy = 1'b1;
               rx_t    = 0;
            end
         end else begin
            rx_t++;
            if (rx_t == HALF) begin
               check("start_bit", int'(tx), 0);
            end else if (rx_t > HALF && ((rx_t - HALF) % CPB) == 0) begin
               if ((rx_t - HALF) / CPB <= 8) begin
                  rx_sh = {tx, rx_sh[7:1]};
               end else begin
                  check("stop_bit", int'(tx), 1);
                  rx_busy = 1'b0;
                  rx_count++;
                  line_bytes++;
                  if (exp_q.size() == 0) begin
                     n_checks++;
                     $display("FAIL unexpected_byte: got %02h, required no byte", rx_sh);
                  end else begin
                     check("rx_byte", int'(rx_sh), int'(exp_q.pop_front()));
                  end
               end
            end
         end
      end
   end

   task automatic pulse(input logic a, input logic b, input logic c);
      @(negedge clk);
      p1 = a; p2 = b; clr = c;
      repeat (2) @(negedge clk);
      p1 = 1'b0; p2 = 1'b0; clr = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || active) && t < 4000) begin
         @(negedge clk);
         t++;
      end
      check(name, int'(t < 4000), 1);
      exp_q.delete();
      repeat (20) @(negedge clk);
   endtask

   task automatic wait_bytes(input int target);
      int t;
      t = 0;
      while (rx_count < target && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("byte_wait", int'(t < 2000), 1);
   endtask

   // a run of n points starting from idle: first line shows +1, one follow-up shows the final count
   task automatic burst(input int who, input int n);
      for (int i = 0; i < n; i++) begin
         pulse(who == 1, who == 2, 1'b0);
         if (who == 1) m1 = (m1 + 1) % 100;
         else m2 = (m2 + 1) % 100;
         if (i == 0) push_line(m1, m2);
      end
      if (n > 1) push_line(m1, m2);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int base;
      repeat (3) @(negedge clk);
      check("rst_tx", int'(tx), 1);
      check("rst_active", int'(active), 0);
      check("rst_done", int'(done), 0);
      check("rst_p1", int'(s1), 0);
      check("rst_p2", int'(s2), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // single point with event-to-start-bit latency
      d0 = done_count;
      @(negedge clk);
      p1 = 1'b1;
      @(posedge clk);
      repeat (2) @(posedge clk);
      #1 check("score_k2", int'(s1), 0);
      @(posedge clk);
      #1 check("score_k3", int'(s1), 8'h01);
      @(posedge clk);
      #1 check("idle_k4", int'({tx, active}), 2'b10);
      @(posedge clk);
      #1 check("start_k5", int'({tx, active}), 2'b01);
      p1 = 1'b0;
      m1 = 1;
      push_line(m1, m2);
      wait_idle("single_line");
      check("single_done", done_count - d0, 1);

      d0 = done_count;
      burst(2, 9);
      wait_idle("carry_9");
      check("p2_09", int'(s2), bcd(m2));
      check("p2_09_lines", done_count - d0, 2);
      burst(2, 1);
      wait_idle("carry_10");
      check("p2_10", int'(s2), 8'h10);

      pulse(1'b0, 1'b0, 1'b1);
      m1 = 0; m2 = 0;
      push_line(m1, m2);
      wait_idle("clear_line");
      check("clear_p1", int'(s1), 0);
      check("clear_p2", int'(s2), 0);

      burst(2, 99);
      wait_idle("to_99");
      check("p2_99", int'(s2), 8'h99);
      burst(2, 1);
      wait_idle("wrap_00");
      check("p2_wrap", int'(s2), 8'h00);

      d0 = done_count;
      pulse(1'b1, 1'b1, 1'b0);
      m1++; m2++;
      push_line(m1, m2);
      wait_idle("both_line");
      check("both_p1", int'(s1), 8'h01);
      check("both_p2", int'(s2), 8'h01);
      check("both_one_line", done_count - d0, 1);

      pulse(1'b1, 1'b0, 1'b1);
      m1 = 0; m2 = 0;
      push_line(m1, m2);
      wait_idle("clear_p1_line");
      check("clrp1_p1", int'(s1), 0);
      check("clrp1_p2", int'(s2), 0);

      // three p1 points during byte 4 of a line
      d0 = done_count;
      pulse(1'b0, 1'b1, 1'b0);
      m2++;
      push_line(m1, m2);
      base = rx_count;
      wait_bytes(base + 4);
      for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1'b0);
      m1 += 3;
      push_line(m1, m2);
      wait_idle("midline");
      check("midline_lines", done_count - d0, 2);
      check("midline_p1", int'(s1), 8'h03);
      check("midline_idle", int'(active), 0);

      // reset inside the data bits of byte 6
      pulse(1'b1, 1'b0, 1'b0);
      m1++;
      push_line(m1, m2);
      base = rx_count;
      wait_bytes(base + 6);
      repeat (2 * CPB + 2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_tx", int'(tx), 1);
      check("mid_rst_active", int'(active), 0);
      check("mid_rst_p1", int'(s1), 0);
      check("mid_rst_p2", int'(s2), 0);
      check("mid_rst_bytes", rx_count - base, 6);
      exp_q.delete();
      m1 = 0; m2 = 0;
      base = rx_count;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (300) @(negedge clk);
      check("post_rst_bytes", rx_count - base, 0);
      check("post_rst_active", int'(active), 0);
      check("post_rst_tx", int'(tx), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
